// File: rtl/prog_pkg.sv
// Shared constants, state encoding and write payload for the program fetch unit.
package prog_pkg;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam int unsigned DW    = 8;

  localparam logic [DW-1:0] NOP_OPC  = 8'h00;
  localparam logic [DW-1:0] HALT_OPC = 8'hF0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } state_t;

  // One program-store write request
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ram_wr_t;

endpackage

// File: rtl/prog_ram.sv
// Program store: synchronous write, registered read.
module prog_ram #(
  parameter  int unsigned DEPTH = 16,
  parameter  int unsigned DW    = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Write port and registered read port; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/prog_fetch_unit.sv
// Instruction-supply stage: host loads a program byte by byte, CPU fetches by PC.
module prog_fetch_unit
  import prog_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  input  logic          run,
  input  logic          fetch_req,
  input  logic [AW-1:0] pc,
  output logic [DW-1:0] inst,
  output logic          inst_valid,
  output logic [CW-1:0] count,
  output logic          halted
);

  state_t        state_q, state_d;
  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] inst_q, inst_d;
  logic          use_ram_q, use_ram_d;
  logic          inst_valid_q, inst_valid_d;
  logic          halted_q, halted_d;
  logic          ld_ready_q, ld_ready_d;
  logic [DEPTH-1:0] halt_flag_q;
  logic [DW-1:0] rdata;
  ram_wr_t       wr;
  logic          accept;
  logic          in_range;
  logic          last_beat;

  // A byte is taken only when the store has room; the pointer MSB marks a full store
  assign accept    = ld_valid && ld_ready_q && !wr_ptr_q[CW-1];
  assign in_range  = {1'b0, pc} < count_q;
  assign last_beat = ld_last || (count_q == CW'(DEPTH - 1));

  prog_ram #(.DEPTH(DEPTH), .DW(DW)) u_ram (
    .clk   (clk),
    .we    (wr.we),
    .waddr (wr.addr),
    .wdata (wr.data),
    .raddr (pc),
    .rdata (rdata)
  );

  // Shadow of "this location holds HALT_OPC" so the halt decision is made at the fetch edge
  always_ff @(posedge clk) begin
    if (wr.we) begin
      halt_flag_q[wr.addr] <= (wr.data == HALT_OPC);
    end
  end

  // Next-state, pointer, handshake and fetch-result logic
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    inst_d       = inst;
    use_ram_d    = 1'b0;
    inst_valid_d = 1'b0;
    halted_d     = halted_q;
    wr           = '{we: 1'b0, addr: wr_ptr_q[AW-1:0], data: ld_data};

    if (clr) begin
      state_d  = IDLE;
      wr_ptr_d = '0;
      count_d  = '0;
      halted_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            wr.we    = 1'b1;
            wr_ptr_d = wr_ptr_q + CW'(1);
            count_d  = count_q + CW'(1);
            state_d  = last_beat ? IDLE : LOAD;
          end else if (run && !ld_valid && (count_q != '0)) begin
            state_d = RUN;
          end
        end
        LOAD: begin
          if (accept) begin
            wr.we    = 1'b1;
            wr_ptr_d = wr_ptr_q + CW'(1);
            count_d  = count_q + CW'(1);
            state_d  = last_beat ? IDLE : LOAD;
          end
        end
        RUN: begin
          if (fetch_req) begin
            inst_valid_d = 1'b1;
            use_ram_d    = in_range;
            if (!in_range) begin
              inst_d = HALT_OPC;
            end
            if (!in_range || halt_flag_q[pc]) begin
              state_d  = HALT;
              halted_d = 1'b1;
            end
          end
        end
        HALT: begin
          halted_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end

    ld_ready_d = ((state_d == IDLE) || (state_d == LOAD)) && (count_d < CW'(DEPTH));
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      inst_q       <= NOP_OPC;
      use_ram_q    <= 1'b0;
      inst_valid_q <= 1'b0;
      halted_q     <= 1'b0;
      ld_ready_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      inst_q       <= inst_d;
      use_ram_q    <= use_ram_d;
      inst_valid_q <= inst_valid_d;
      halted_q     <= halted_d;
      ld_ready_q   <= ld_ready_d;
    end
  end

  // In-range results come straight from the store's read register; otherwise the held value
  assign inst       = use_ram_q ? rdata : inst_q;
  assign inst_valid = inst_valid_q;
  assign count      = count_q;
  assign halted     = halted_q;
  assign ld_ready   = ld_ready_q;

endmodule

// File: tb/tb_prog_fetch_unit.sv
// Scoreboard bench for prog_fetch_unit: directed loads and fetches, monitor checks inst.
module tb_prog_fetch_unit;

  logic       clk;
  logic       reset;
  logic       clr;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_last;
  logic       ld_ready;
  logic       run;
  logic       fetch_req;
  logic [3:0] pc;
  logic [7:0] inst;
  logic       inst_valid;
  logic [4:0] count;
  logic       halted;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  prog_fetch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .clr        (clr),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .ld_ready   (ld_ready),
    .run        (run),
    .fetch_req  (fetch_req),
    .pc         (pc),
    .inst       (inst),
    .inst_valid (inst_valid),
    .count      (count),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_byte(input logic [7:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic start_run();
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  task automatic fetch(input logic [3:0] a, input logic [7:0] exp);
    fetch_req = 1'b1;
    pc        = a;
    exp_q.push_back(exp);
    tick();
    fetch_req = 1'b0;
  endtask

  // Monitor: every inst_valid pulse must match the oldest expected instruction
  always @(negedge clk) begin
    if (reset && inst_valid) begin
      if (exp_q.size() == 0) begin
        chk("inst_valid_unexpected", 32'(inst_valid), 32'd0);
      end else begin
        chk("inst", 32'(inst), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    reset = 1'b0; clr = 1'b0; ld_valid = 1'b0; ld_data = 8'h00; ld_last = 1'b0;
    run = 1'b0; fetch_req = 1'b0; pc = 4'd0;

    // Reset values while held and after release
    tick();
    chk("rst_inst",       32'(inst),       32'h00);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_ld_ready",   32'(ld_ready),   32'd1);
    chk("rst_count",      32'(count),      32'd0);
    chk("rst_halted",     32'(halted),     32'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("post_rst_inst",       32'(inst),       32'h00);
    chk("post_rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("post_rst_ld_ready",   32'(ld_ready),   32'd1);
    chk("post_rst_count",      32'(count),      32'd0);
    chk("post_rst_halted",     32'(halted),     32'd0);

    // Load three bytes and run to the halt opcode
    load_byte(8'h01, 1'b0);
    load_byte(8'h23, 1'b0);
    load_byte(8'hF0, 1'b1);
    chk("load3_count",    32'(count),    32'd3);
    chk("load3_ld_ready", 32'(ld_ready), 32'd1);
    chk("load3_halted",   32'(halted),   32'd0);
    start_run();
    chk("run_ld_ready", 32'(ld_ready), 32'd0);
    fetch(4'd0, 8'h01);
    fetch(4'd1, 8'h23);
    fetch(4'd2, 8'hF0);
    chk("halt_after_f0", 32'(halted), 32'd1);
    fetch_req = 1'b1; pc = 4'd0;
    tick();
    fetch_req = 1'b0;
    chk("halt_no_valid", 32'(inst_valid), 32'd0);
    chk("halt_inst_hold", 32'(inst), 32'hF0);
    chk("halt_stays", 32'(halted), 32'd1);

    // clr wins over run in HALT; run with an empty store is ignored
    clr = 1'b1; run = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_halted",   32'(halted),   32'd0);
    chk("clr_count",    32'(count),    32'd0);
    chk("clr_ld_ready", 32'(ld_ready), 32'd1);
    tick();
    run = 1'b0;
    chk("empty_run_ignored", 32'(ld_ready), 32'd1);
    fetch_req = 1'b1; pc = 4'd0;
    tick();
    fetch_req = 1'b0;
    chk("idle_fetch_no_valid", 32'(inst_valid), 32'd0);

    // Stream 18 bytes; the last two must be dropped
    for (int i = 0; i < 18; i++) begin
      ld_valid = 1'b1;
      ld_data  = 8'h10 + 8'(i);
      chk("stream_ld_ready", 32'(ld_ready), (i < 16) ? 32'd1 : 32'd0);
      tick();
    end
    ld_valid = 1'b0;
    chk("full_count",    32'(count),    32'd16);
    chk("full_ld_ready", 32'(ld_ready), 32'd0);
    start_run();
    fetch(4'd0,  8'h10);
    fetch(4'd1,  8'h11);
    fetch(4'd15, 8'h1F);
    chk("full_not_halted", 32'(halted), 32'd0);
    chk("full_count_kept", 32'(count),  32'd16);
    clr = 1'b1;
    tick();
    clr = 1'b0;

    // Fetch beyond the loaded program returns the halt opcode
    load_byte(8'h11, 1'b0);
    load_byte(8'h22, 1'b1);
    chk("oor_count", 32'(count), 32'd2);
    start_run();
    fetch(4'd9, 8'hF0);
    chk("oor_halted", 32'(halted), 32'd1);
    chk("oor_inst", 32'(inst), 32'hF0);
    clr = 1'b1;
    tick();
    clr = 1'b0;

    // Reset in the middle of a load abandons the partial program
    for (int i = 0; i < 5; i++) begin
      load_byte(8'h40 + 8'(i), 1'b0);
    end
    chk("midload_count", 32'(count), 32'd5);
    chk("midload_ld_ready", 32'(ld_ready), 32'd1);
    reset = 1'b0;
    #1;
    chk("midrst_count",    32'(count),    32'd0);
    chk("midrst_ld_ready", 32'(ld_ready), 32'd1);
    chk("midrst_halted",   32'(halted),   32'd0);
    tick();
    reset = 1'b1;
    tick();
    load_byte(8'hAA, 1'b1);
    chk("reload_count", 32'(count), 32'd1);
    start_run();
    fetch(4'd0, 8'hAA);
    tick();
    tick();
    chk("reload_not_halted", 32'(halted), 32'd0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_fetch_unit.md
Name: prog_fetch_unit

Overview:
- Instruction-supply stage directly upstream of the CPU core.
- Holds a 16 x 8 program store that a host loads byte by byte over a valid/ready handshake.
- In run mode it answers the CPU's 4-bit PC fetch requests with the 8-bit instruction one cycle later.
- Detects the halt opcode and freezes the instruction stream until it is cleared.

Parameters:
- DEPTH, 16, number of program bytes; address width is clog2(DEPTH) = 4.
- NOP_OPC, 8'h00, value driven on inst when no valid instruction is present.
- HALT_OPC, 8'hF0, opcode that ends execution.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear back to IDLE with an empty program store.
- ld_valid  in  1  host presents a program byte.
- ld_data  in  8  program byte.
- ld_last  in  1  qualifies the final byte of the load.
- ld_ready  out  1  block can accept a program byte.
- run  in  1  start execution; level sampled in IDLE.
- fetch_req  in  1  CPU requests the instruction at pc.
- pc  in  4  CPU program counter.
- inst  out  8  instruction to the CPU.
- inst_valid  out  1  inst carries a fresh fetch result; one-cycle pulse per request.
- count  out  5  number of bytes loaded, 0..16.
- halted  out  1  execution stopped.

Behaviour:
- Reset values, applied asynchronously while reset = 0:
  - state = IDLE, wr_ptr = 0, count = 0.
  - inst = NOP_OPC, inst_valid = 0, halted = 0.
  - ld_ready = 1, because IDLE accepts bytes.
- Memory contents are not reset. Locations at or above count are never exposed.
- States: IDLE, LOAD, RUN, HALT. clr has priority over every other input in every state: next state IDLE, wr_ptr = 0, count = 0, inst_valid = 0, halted = 0.
- IDLE:
  - ld_ready = 1.
  - ld_valid writes mem[0] <= ld_data, sets wr_ptr = 1 and count = 1.
    - ld_last = 1 on that byte: stay in IDLE.
    - Otherwise: go to LOAD.
  - run = 1 with count > 0 and no ld_valid: go to RUN.
  - run with count = 0 is ignored.
  - ld_valid and run together: the load wins and run is ignored.
- LOAD:
  - ld_ready = 1 while count < 16.
  - Each ld_valid && ld_ready writes mem[wr_ptr], then wr_ptr++ and count++.
  - ld_last, or the write that makes count reach 16: go to IDLE.
  - run is ignored.
- Loading from IDLE when count > 0 appends at wr_ptr. Only clr restarts at address 0.
- When count = 16, ld_ready = 0 and further ld_valid is dropped with no write and no counter change. wr_ptr does not wrap.
- RUN:
  - ld_ready = 0.
  - A fetch_req sampled at edge N produces inst and inst_valid = 1 during cycle N+1.
  - Back-to-back requests are supported, giving one result per cycle.
  - No request: inst_valid = 0 and inst holds its last value.
  - pc < count: inst = mem[pc].
  - pc >= count: inst = HALT_OPC.
  - If the delivered byte equals HALT_OPC, go to HALT at the same edge.
- HALT:
  - halted = 1 and inst_valid = 0.
  - inst holds HALT_OPC.
  - fetch_req, run and ld_valid are ignored.
  - Only clr or reset leaves this state.
- Reset asserted mid-load or mid-run: immediate return to the reset values. A partially loaded program is abandoned because count = 0.

Decomposition:
- Shared package prog_pkg holds:
  - the state encoding (IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, HALT = 2'd3);
  - NOP_OPC and HALT_OPC defaults;
  - the DEPTH constant.
- One sub-module, prog_ram:
  - DEPTH x 8 synchronous-write store with a registered read;
  - ports: clk, we, waddr, wdata, raddr, rdata.
- The FSM, pointers and handshake logic stay in prog_fetch_unit.

Test Plan:
- Reset: hold reset = 0 for 2 cycles, then release. Check inst = 8'h00, inst_valid = 0, ld_ready = 1, count = 0 and halted = 0, both during and after reset.
- Load and run:
  - Load 8'h01, 8'h23, 8'hF0 with ld_last on the third byte. Expect count = 3, then return to IDLE.
  - Pulse run, then request pc = 0, 1, 2 on consecutive cycles. Expect inst = 01, 23, F0 with inst_valid high for 3 cycles.
  - Expect halted = 1 after F0; a later fetch_req gives no inst_valid.
- Full store: stream 18 bytes 8'h10..8'h21 with ld_valid held high. Expect ld_ready to drop after the 16th byte, count = 16, and bytes 8'h20 and 8'h21 not written.
- Out-of-range fetch: after loading 2 bytes and starting run, request pc = 4'd9. Expect inst = 8'hF0 and inst_valid = 1, then halted = 1.
- clr priority: in HALT, assert clr together with run. Expect IDLE, count = 0 and halted = 0; run is ignored because count = 0.
- Reset mid-load: drop reset after 5 of 10 bytes. Expect count = 0 and ld_ready = 1. Reloading 8'hAA and running pc = 0 returns 8'hAA.
